// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, lane steering, dmem req/gnt/rvalid, load extension.
// Response 1 cycle after accept (misaligned/NONE), 2 (store) or 3+ (load); req_ready_o low while busy.

package lsu_pkg;
    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD
    } lsu_op_t;
endpackage

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  lsu_op_t       lsu_op_i,
    input  logic [63:0]   addr_i,
    input  logic [63:0]   wdata_i,
    output logic          resp_valid_o,
    output logic          resp_err_o,
    output logic [63:0]   resp_rdata_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [63:0]   dmem_addr_o,
    output logic [7:0]    dmem_be_o,
    output logic [63:0]   dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [63:0]   dmem_rdata_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state, state_nxt;
    lsu_op_t       op_q;
    logic [2:0]    off_q;
    logic [CW-1:0] cnt_q;

    logic [1:0]    sz;
    logic [2:0]    amask;
    logic [7:0]    be_base, be_nxt;
    logic [63:0]   wmask, wdata_nxt;
    logic          is_load, is_store, misaligned, start, timeout;

    logic          resp_fire, resp_err_d;
    logic [63:0]   resp_data_d, rd_shift, load_ext;

    // Access decode of the op presented by execute
    always_comb begin
        sz = 2'd3;
        unique case (lsu_op_i)
            LB, LBU, SB: sz = 2'd0;
            LH, LHU, SH: sz = 2'd1;
            LW, LWU, SW: sz = 2'd2;
            default:     sz = 2'd3;
        endcase
        is_load  = lsu_op_i inside {LB, LH, LW, LD, LBU, LHU, LWU};
        is_store = lsu_op_i inside {SB, SH, SW, SD};
        unique case (sz)
            2'd0:    begin amask = 3'b000; be_base = 8'h01; wmask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin amask = 3'b001; be_base = 8'h03; wmask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin amask = 3'b011; be_base = 8'h0F; wmask = 64'h0000_0000_FFFF_FFFF; end
            default: begin amask = 3'b111; be_base = 8'hFF; wmask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        misaligned = (is_load || is_store) && (|(addr_i[2:0] & amask));
        be_nxt     = be_base << addr_i[2:0];
        wdata_nxt  = (wdata_i & wmask) << {addr_i[2:0], 3'b000};
    end

    assign start   = req_valid_i && (state == S_IDLE) && (is_load || is_store) && !misaligned;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_REQ;
            S_REQ:   if (dmem_gnt_i) state_nxt = dmem_we_o ? S_IDLE : S_RESP;
            S_RESP:  if (dmem_rvalid_i || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction at the latched byte offset
    always_comb begin
        rd_shift = dmem_rdata_i >> {off_q, 3'b000};
        unique case (op_q)
            LB:      load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
            LBU:     load_ext = {56'b0,              rd_shift[7:0]};
            LH:      load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            LHU:     load_ext = {48'b0,              rd_shift[15:0]};
            LW:      load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            LWU:     load_ext = {32'b0,              rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        req_ready_o = (state == S_IDLE);
        resp_fire   = 1'b0;
        resp_err_d  = 1'b0;
        resp_data_d = 64'b0;
        unique case (state)
            S_IDLE: if (req_valid_i && !start) begin
                resp_fire  = 1'b1;
                resp_err_d = misaligned;
            end
            S_REQ: if (dmem_gnt_i && dmem_we_o) resp_fire = 1'b1;
            S_RESP: begin
                // rvalid takes priority over a coincident timeout
                if (dmem_rvalid_i) begin
                    resp_fire   = 1'b1;
                    resp_data_d = load_ext;
                end else if (timeout) begin
                    resp_fire  = 1'b1;
                    resp_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 64'b0;
            dmem_be_o    <= 8'b0;
            dmem_wdata_o <= 64'b0;
            op_q         <= LSU_NONE;
            off_q        <= 3'b0;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= 64'b0;
        end else begin
            if (start) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= is_store;
                dmem_addr_o  <= {addr_i[63:3], 3'b000};
                dmem_be_o    <= be_nxt;
                dmem_wdata_o <= is_store ? wdata_nxt : 64'b0;
                op_q         <= lsu_op_i;
                off_q        <= addr_i[2:0];
            end
            if (state == S_REQ && dmem_gnt_i) begin
                dmem_req_o <= 1'b0;
                cnt_q      <= '0;
            end
            if (state == S_RESP && !dmem_rvalid_i && !timeout) cnt_q <= cnt_q + 1'b1;
            resp_valid_o <= resp_fire;
            if (resp_fire) begin
                resp_err_o   <= resp_err_d;
                resp_rdata_o <= resp_data_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short response timeout.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    lsu_op_t     lsu_op;
    logic [63:0] addr, wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .lsu_op_i(lsu_op), .addr_i(addr), .wdata_i(wdata),
        .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Minimum-latency load: gnt in the request cycle, rvalid the cycle after
    task automatic do_load(input string tag, input lsu_op_t op, input logic [63:0] a,
                           input logic [63:0] exp_addr, input logic [7:0] exp_be,
                           input logic [63:0] rd, input logic [63:0] exp);
        req_valid = 1'b1; lsu_op = op; addr = a;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE;
        chk1 ({tag, "_req"},   dmem_req, 1'b1);
        chk1 ({tag, "_we"},    dmem_we, 1'b0);
        chk64({tag, "_addr"},  dmem_addr, exp_addr);
        chk8 ({tag, "_be"},    dmem_be, exp_be);
        chk64({tag, "_wdata"}, dmem_wdata, 64'h0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk1 ({tag, "_req_drop"}, dmem_req, 1'b0);
        chk1 ({tag, "_no_early"}, resp_valid, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        tick();
        dmem_rvalid = 1'b0;
        chk1 ({tag, "_rvld"},  resp_valid, 1'b1);
        chk1 ({tag, "_rerr"},  resp_err, 1'b0);
        chk64({tag, "_rdata"}, resp_rdata, exp);
        tick();
        chk1 ({tag, "_pulse"}, resp_valid, 1'b0);
        chk64({tag, "_hold"},  resp_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; lsu_op = LSU_NONE; addr = '0; wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        chk1 ("rst_ready", req_ready, 1'b1);
        chk1 ("rst_req", dmem_req, 1'b0);
        chk1 ("rst_rvld", resp_valid, 1'b0);
        chk8 ("rst_be", dmem_be, 8'h00);
        chk64("rst_rdata", resp_rdata, 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // SW at offset 4, gnt in the request cycle
        req_valid = 1'b1; lsu_op = SW; addr = 64'h1004; wdata = 64'hDEADBEEF;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE;
        chk1 ("sw_req", dmem_req, 1'b1);
        chk1 ("sw_we", dmem_we, 1'b1);
        chk1 ("sw_busy", req_ready, 1'b0);
        chk64("sw_addr", dmem_addr, 64'h1000);
        chk8 ("sw_be", dmem_be, 8'hF0);
        chk64("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk1 ("sw_req_drop", dmem_req, 1'b0);
        chk1 ("sw_rvld", resp_valid, 1'b1);
        chk1 ("sw_rerr", resp_err, 1'b0);
        chk1 ("sw_ready", req_ready, 1'b1);
        tick();
        chk1 ("sw_pulse", resp_valid, 1'b0);

        do_load("lb",  LB,  64'h1003, 64'h1000, 8'h08, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
        do_load("lbu", LBU, 64'h1003, 64'h1000, 8'h08, 64'h00000000_80000000, 64'h00000000_00000080);
        do_load("lh",  LH,  64'h1006, 64'h1000, 8'hC0, 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001);
        do_load("lwu", LWU, 64'h1004, 64'h1000, 8'hF0, 64'hF0000001_12345678, 64'h00000000_F0000001);
        do_load("ld",  LD,  64'h1008, 64'h1008, 8'hFF, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);

        // Misaligned LW: immediate error, no memory access
        req_valid = 1'b1; lsu_op = LW; addr = 64'h1002;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE;
        chk1 ("mis_req", dmem_req, 1'b0);
        chk1 ("mis_rvld", resp_valid, 1'b1);
        chk1 ("mis_rerr", resp_err, 1'b1);
        chk64("mis_rdata", resp_rdata, 64'h0);
        chk1 ("mis_ready", req_ready, 1'b1);

        // LSU_NONE: clean response with zero data
        req_valid = 1'b1; lsu_op = LSU_NONE;
        tick();
        req_valid = 1'b0;
        chk1 ("none_req", dmem_req, 1'b0);
        chk1 ("none_rvld", resp_valid, 1'b1);
        chk1 ("none_rerr", resp_err, 1'b0);

        // SD with gnt withheld 5 cycles
        req_valid = 1'b1; lsu_op = SD; addr = 64'h2000; wdata = 64'h11223344_55667788;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE;
        for (int i = 0; i < 5; i++) begin
            chk1 ("stall_req", dmem_req, 1'b1);
            chk64("stall_addr", dmem_addr, 64'h2000);
            chk8 ("stall_be", dmem_be, 8'hFF);
            chk64("stall_wdata", dmem_wdata, 64'h11223344_55667788);
            chk1 ("stall_ready", req_ready, 1'b0);
            chk1 ("stall_norsp", resp_valid, 1'b0);
            tick();
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk1 ("stall_done", resp_valid, 1'b1);
        chk1 ("stall_err", resp_err, 1'b0);

        // Timeout: 4 RESP cycles without rvalid
        tick();
        req_valid = 1'b1; lsu_op = LD; addr = 64'h3000;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1 ("to_wait_rvld", resp_valid, 1'b0);
            chk1 ("to_wait_busy", req_ready, 1'b0);
        end
        tick();
        chk1 ("to_rvld", resp_valid, 1'b1);
        chk1 ("to_rerr", resp_err, 1'b1);
        chk64("to_rdata", resp_rdata, 64'h0);
        chk1 ("to_ready", req_ready, 1'b1);
        dmem_rvalid = 1'b1; dmem_rdata = 64'hBAD0BAD0_BAD0BAD0;
        tick();
        dmem_rvalid = 1'b0;
        chk1 ("late_ignored", resp_valid, 1'b0);
        chk1 ("late_ready", req_ready, 1'b1);
        do_load("post_to", LW, 64'h3004, 64'h3000, 8'hF0, 64'h80000000_00000000, 64'hFFFFFFFF_80000000);

        // rvalid in the timeout cycle wins
        req_valid = 1'b1; lsu_op = LD; addr = 64'h3010;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick(); tick(); tick();
        chk1 ("edge_busy", req_ready, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0F0E0D0C_0B0A0908;
        tick();
        dmem_rvalid = 1'b0;
        chk1 ("edge_rvld", resp_valid, 1'b1);
        chk1 ("edge_rerr", resp_err, 1'b0);
        chk64("edge_rdata", resp_rdata, 64'h0F0E0D0C_0B0A0908);

        // Reset while in RESP
        req_valid = 1'b1; lsu_op = LD; addr = 64'h5000;
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk1 ("mrst_ready", req_ready, 1'b1);
        chk1 ("mrst_req", dmem_req, 1'b0);
        chk64("mrst_addr", dmem_addr, 64'h0);
        chk8 ("mrst_be", dmem_be, 8'h00);
        chk64("mrst_rdata", resp_rdata, 64'h0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'h77777777_77777777;
        tick();
        dmem_rvalid = 1'b0;
        chk1 ("mrst_norsp", resp_valid, 1'b0);
        tick();
        chk1 ("mrst_norsp2", resp_valid, 1'b0);

        // Back-to-back SD then LD with valid held and gnt held high
        req_valid = 1'b1; lsu_op = SD; addr = 64'h4000; wdata = 64'hA5A5A5A5_5A5A5A5A; dmem_gnt = 1'b1;
        tick();
        lsu_op = LD; addr = 64'h4008;
        chk1 ("b2b_sd_req", dmem_req, 1'b1);
        chk1 ("b2b_sd_we", dmem_we, 1'b1);
        chk1 ("b2b_busy", req_ready, 1'b0);
        tick();
        chk1 ("b2b_sd_rsp", resp_valid, 1'b1);
        chk1 ("b2b_ready", req_ready, 1'b1);
        chk1 ("b2b_req_low", dmem_req, 1'b0);
        tick();
        req_valid = 1'b0; lsu_op = LSU_NONE;
        chk1 ("b2b_ld_req", dmem_req, 1'b1);
        chk1 ("b2b_ld_we", dmem_we, 1'b0);
        chk64("b2b_ld_addr", dmem_addr, 64'h4008);
        chk1 ("b2b_ld_norsp", resp_valid, 1'b0);
        tick();
        dmem_gnt = 1'b0;
        chk1 ("b2b_ld_drop", dmem_req, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'hCAFEF00D_12345678;
        tick();
        dmem_rvalid = 1'b0;
        chk1 ("b2b_ld_rsp", resp_valid, 1'b1);
        chk64("b2b_ld_rdata", resp_rdata, 64'hCAFEF00D_12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
